// File: rtl/rom_port_responder_if.sv
// Toggle-handshake port plus grant/valid memory bus
// seen from the responder (slave) and its peers (master).
interface rom_port_responder_if #(
  parameter int AW = 23
);
  logic          port_req;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_d;
  logic          port_ack;
  logic [15:0]   port_q;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [15:0]   mem_din;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [15:0]   mem_rdata;

  modport slave (
    input  port_req, port_a, port_ds,
    input  port_we, port_d,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output port_ack, port_q,
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_din
  );

  modport master (
    output port_req, port_a, port_ds,
    output port_we, port_d,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  port_ack, port_q,
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_din
  );
endinterface

// File: rtl/rom_port_responder.sv
// Queues port_req toggles and replays them in order on
// the grant/valid memory bus, toggling port_ack per completion.
module rom_port_responder #(
  parameter int AW    = 23,
  parameter int DEPTH = 4
) (
  input  logic clk_mem,
  input  logic reset_n,
  rom_port_responder_if.slave bus,
  output logic busy,
  output logic overflow
);
  localparam int L = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RWAIT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [L:0] ONE = {{L{1'b0}}, 1'b1};

  logic [1:0]    state;
  logic          req_seen;
  logic [L:0]    wr_ptr;
  logic [L:0]    rd_ptr;
  logic [L-1:0]  wi;
  logic [L-1:0]  ri;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          take;

  logic [AW-1:0] f_a  [DEPTH];
  logic [1:0]    f_ds [DEPTH];
  logic          f_we [DEPTH];
  logic [15:0]   f_d  [DEPTH];

  assign wi    = wr_ptr[L-1:0];
  assign ri    = rd_ptr[L-1:0];
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[L] != rd_ptr[L]) && (wi == ri);
  assign push  = bus.port_req != req_seen;
  assign pop   = state == DONE;
  // a pop in the same edge frees the slot being written
  assign take  = push && (!full || pop);

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      req_seen <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        req_seen <= bus.port_req;
      if (take)
        wr_ptr <= wr_ptr + ONE;
      if (push && !take)
        overflow <= 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (take) begin
      f_a[wi]  <= bus.port_a;
      f_ds[wi] <= bus.port_ds;
      f_we[wi] <= bus.port_we;
      f_d[wi]  <= bus.port_d;
    end
  end

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.port_ack <= 1'b0;
      bus.port_q   <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_be   <= '0;
      bus.mem_din  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            if (f_we[ri] && f_ds[ri] == 2'b00) begin
              state <= DONE;
            end else begin
              state        <= ISSUE;
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= f_we[ri];
              bus.mem_addr <= f_a[ri];
              bus.mem_be   <= f_we[ri] ? f_ds[ri] : 2'b11;
              bus.mem_din  <= f_d[ri];
            end
          end
        end
        ISSUE: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            state       <= bus.mem_we ? DONE : RWAIT;
          end
        end
        RWAIT: begin
          if (bus.mem_rvalid) begin
            bus.port_q <= bus.mem_rdata;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.port_ack <= ~bus.port_ack;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n)
      busy <= 1'b0;
    else
      busy <= !empty || state != IDLE;
  end
endmodule

// File: tb/tb_rom_port_responder.sv
// Directed scoreboard bench: memory-side and ack-side
// monitors pop expectations queued by the stimulus.
module tb_rom_port_responder;
  localparam int AW = 23;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [1:0]    be;
    logic [15:0]   d;
  } mreq_t;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic overflow;

  rom_port_responder_if #(.AW(AW)) bus ();

  rom_port_responder #(.AW(AW), .DEPTH(4)) dut (
    .clk_mem  (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ack = 0;
  int ack_cyc = 0;
  int tog_cyc = 0;
  int req_cycles = 0;
  logic [15:0] last_q = '0;
  mreq_t mq[$];
  logic [15:0] aq[$];
  bit rv_en = 1'b1;
  bit pend = 1'b0;
  logic [15:0] pdata = '0;
  logic prev_ack = 1'b0;
  bit req_wait = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] rdata_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hFEEF;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [AW-1:0] a,
                        input logic [1:0] ds,
                        input logic we,
                        input logic [15:0] d,
                        input bit drop);
    mreq_t e;
    bus.port_a   = a;
    bus.port_ds  = ds;
    bus.port_we  = we;
    bus.port_d   = d;
    bus.port_req = ~bus.port_req;
    tog_cyc = cyc + 1;
    if (!drop) begin
      if (!we) last_q = rdata_of(a);
      if (!(we && ds == 2'b00)) begin
        e.we = we;
        e.a  = a;
        e.be = we ? ds : 2'b11;
        e.d  = d;
        mq.push_back(e);
      end
      aq.push_back(last_q);
    end
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (n_ack < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ack_count", 64'(n_ack), 64'(target));
    tick();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.port_req = 1'b0;
    mq.delete();
    aq.delete();
    last_q = '0;
    #1;
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {bus.port_ack, bus.port_q, bus.mem_req,
                 bus.mem_we, bus.mem_addr, bus.mem_be,
                 bus.mem_din, busy, overflow}, 64'd0);
  endtask

  // memory side: grant checks and read return
  always @(negedge clk) begin
    mreq_t e;
    if (!reset_n) begin
      prev_ack = 1'b0;
      req_wait = 1'b0;
      pend = 1'b0;
    end else begin
      if (req_wait) check("req_hold", 64'(bus.mem_req), 64'd1);
      req_wait = bus.mem_req && !bus.mem_gnt;
      if (bus.mem_req) req_cycles++;
      if (bus.mem_req && bus.mem_gnt) begin
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: addr %0h",
                   bus.mem_addr);
        end else begin
          e = mq.pop_front();
          check("mem_we", 64'(bus.mem_we), 64'(e.we));
          check("mem_addr", 64'(bus.mem_addr), 64'(e.a));
          check("mem_be", 64'(bus.mem_be), 64'(e.be));
          if (e.we)
            check("mem_din", 64'(bus.mem_din), 64'(e.d));
        end
        if (!bus.mem_we && rv_en) begin
          pend  = 1'b1;
          pdata = rdata_of(bus.mem_addr);
        end
      end
      if (bus.port_ack !== prev_ack) begin
        n_ack++;
        ack_cyc  = cyc;
        prev_ack = bus.port_ack;
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: q %0h", bus.port_q);
        end else begin
          check("port_q", 64'(bus.port_q), 64'(aq.pop_front()));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.mem_rvalid = pend;
    bus.mem_rdata  = pend ? pdata : 16'h0;
    pend = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t limit 200000", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int rc;
    reset_n        = 1'b0;
    bus.port_req   = 1'b0;
    bus.port_a     = '0;
    bus.port_ds    = '0;
    bus.port_we    = 1'b0;
    bus.port_d     = '0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    tick();
    tick();
    check_reset_outs("reset_outs");
    reset_n = 1'b1;
    tick();

    // single write, grant tied high
    rc = req_cycles;
    toggle(23'h000123, 2'b01, 1'b1, 16'h5A5A, 1'b0);
    wait_acks(1, 20);
    check("wr_latency", 64'(ack_cyc - tog_cyc), 64'd3);
    check("wr_req_cycles", 64'(req_cycles - rc), 64'd1);
    check("wr_ack", 64'(bus.port_ack), 64'd1);
    check("wr_busy_low", 64'(busy), 64'd0);

    // read, grant held low for two request cycles
    bus.mem_gnt = 1'b0;
    toggle(23'h004000, 2'b00, 1'b0, 16'h0, 1'b0);
    repeat (4) tick();
    bus.mem_gnt = 1'b1;
    wait_acks(2, 20);
    check("rd_latency", 64'(ack_cyc - tog_cyc), 64'd6);
    check("rd_q", 64'(bus.port_q), 64'hBEEF);

    // ds=00 write skips the memory
    rc = req_cycles;
    toggle(23'h000007, 2'b00, 1'b1, 16'h1111, 1'b0);
    wait_acks(3, 20);
    check("ds0_latency", 64'(ack_cyc - tog_cyc), 64'd2);
    check("ds0_no_req", 64'(req_cycles - rc), 64'd0);
    check("ds0_q_hold", 64'(bus.port_q), 64'hBEEF);

    // six back-to-back toggles into a stalled bus
    bus.mem_gnt = 1'b0;
    base = n_ack;
    for (int i = 0; i < 6; i++) begin
      toggle(23'(32'h10 + i), 2'b11, 1'b1,
             16'(32'hA000 + i), i >= 4);
      tick();
    end
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_busy", 64'(busy), 64'd1);
    bus.mem_gnt = 1'b1;
    wait_acks(base + 4, 60);
    repeat (8) tick();
    check("ovf_acks", 64'(n_ack - base), 64'd4);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_busy_end", 64'(busy), 64'd0);
    check("ovf_mq_left", 64'(mq.size()), 64'd0);

    // reset while waiting for read data
    rv_en = 1'b0;
    toggle(23'h004000, 2'b11, 1'b0, 16'h0, 1'b0);
    repeat (3) tick();
    check("pre_rst_ack", 64'(bus.port_ack), 64'd1);
    apply_reset();
    check_reset_outs("rwait_reset_outs");
    tick();
    reset_n = 1'b1;
    rv_en = 1'b1;
    tick();

    // reset while a request is pending drops mem_req at once
    bus.mem_gnt = 1'b0;
    toggle(23'h000055, 2'b11, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    check("issue_req", 64'(bus.mem_req), 64'd1);
    apply_reset();
    check("async_req_drop", 64'(bus.mem_req), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // full FIFO, new toggle lands on the DONE edge
    base = n_ack;
    for (int i = 0; i < 4; i++) begin
      toggle(23'(32'h20 + i), 2'b10, 1'b1,
             16'(32'hC000 + i), 1'b0);
      tick();
    end
    bus.mem_gnt = 1'b1;
    tick();
    toggle(23'h000024, 2'b01, 1'b1, 16'hC004, 1'b0);
    tick();
    check("fp_no_ovf", 64'(overflow), 64'd0);
    wait_acks(base + 5, 80);
    repeat (8) tick();
    check("fp_acks", 64'(n_ack - base), 64'd5);
    check("fp_ovf_end", 64'(overflow), 64'd0);
    check("fp_mq_left", 64'(mq.size()), 64'd0);
    check("fp_aq_left", 64'(aq.size()), 64'd0);
    check("fp_busy_end", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_port_responder.md
# rom_port_responder

Responder end of the toggle-handshake SDRAM port used by the ROM download controller (`portN_req` / `portN_a` / `portN_ds` / `portN_we` / `portN_d` → `portN_ack` / `portN_q`). It detects each `port_req` toggle as one transaction and queues it in a small FIFO, because the initiator fires on every `ioctl_wr` edge without waiting for ack. It executes queued transactions in order against a simple grant/valid memory bus, then toggles `port_ack` once per completed transaction. It sits in the `clk_mem` domain between the download controller and the SDRAM controller core.

## Interface
- `AW`, 23, word address width of `port_a` / `mem_addr`
- `DEPTH`, 4, pending-transaction FIFO entries; power of 2, ≥2
- `clk_mem` in 1: sole clock; all ports are synchronous to it
- `reset_n` in 1: asynchronous, active-low reset
- `port_req` in 1: each level change is one transaction request
- `port_a` in AW: word address, sampled with the toggle
- `port_ds` in 2: byte strobes; [1] = `d[15:8]`, [0] = `d[7:0]`
- `port_we` in 1: 1 = write, 0 = read
- `port_d` in 16: write data
- `port_ack` out 1: toggles once per completed transaction
- `port_q` out 16: read data; valid from the edge `port_ack` toggles for a read
- `mem_req` out 1: memory request; held until granted
- `mem_we`, `mem_addr`[AW], `mem_be`[2], `mem_din`[16] out: request fields; stable while `mem_req`=1
- `mem_gnt` in 1: request accepted on this edge
- `mem_rvalid` in 1, `mem_rdata` in 16: read return, earliest one cycle after `mem_gnt`
- `busy` out 1: FIFO non-empty or FSM not IDLE
- `overflow` out 1: sticky; a toggle was dropped

## Operation
- Edge detect: register `req_seen` (reset 0). At any edge where `port_req != req_seen`:
  - set `req_seen <= port_req`;
  - push {`port_a`, `port_ds`, `port_we`, `port_d`}.
- Push when full: drop the entry and set `overflow`. `overflow` clears only on reset. A dropped transaction never produces an ack.
- Full with pop on the same edge: the push is accepted, and occupancy is unchanged.
- FIFO uses wrap-around pointers of log2(DEPTH)+1 bits. Full when the MSBs differ and the LSBs are equal.
- FSM states:
  - IDLE: if FIFO is non-empty, go to ISSUE (head entry drives `mem_*`). Exception: a write with `ds`=00 goes directly to DONE and makes no memory access.
  - ISSUE: `mem_req`=1. On `mem_gnt`: a write goes to DONE, a read goes to RWAIT.
  - RWAIT: on `mem_rvalid`, `port_q <= mem_rdata`, then go to DONE. `mem_rvalid` arriving outside RWAIT is ignored.
  - DONE: `port_ack <= ~port_ack`, pop the FIFO, go to IDLE.
- Read ignores `ds` and drives `mem_be`=11. Write drives `mem_be = ds`.
- `port_q` holds its value across writes.
- Transactions complete strictly in FIFO order.

## Timing
- Reset values:
  - outputs: `port_ack` 0, `port_q` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_din` 0, `busy` 0, `overflow` 0;
  - internal: FSM IDLE, FIFO empty, `req_seen` 0.
- The initiator must hold `port_req` at 0 through reset. A 1 on `port_req` at reset release counts as a toggle.
- Reset mid-transaction: `mem_req` drops asynchronously. No ack is issued and the queue is lost.
- Latency, toggle sampled at edge E, `mem_gnt`=1 on first request cycle:
  - write: `mem_req` high from E+1, DONE at E+2, `port_ack` toggles at E+3;
  - read with `mem_rvalid` in the first RWAIT cycle: `port_q` is loaded at E+3 and `port_ack` toggles at E+4;
  - each grant wait cycle adds one cycle.
- Throughput: one write per 3 cycles. The FIFO absorbs bursts of DEPTH toggles.
- `busy` is registered. It goes high the edge after a push and low the edge after the final pop.

## Test plan
- Single write: toggle `port_req` 0→1 with a=0x000123, ds=01, we=1, d=0x5A5A, `mem_gnt` tied 1 → one `mem_req` cycle with be=01, din=0x5A5A, addr=0x000123; `port_ack`=1 three edges after the toggle.
- Read with stall: toggle a read of a=0x4000; `mem_gnt` low for 2 cycles; `mem_rvalid`/`rdata`=0xBEEF one cycle after grant → `port_q`=0xBEEF and `port_ack` toggles 6 edges after the toggle; `mem_req` is never deasserted before grant.
- Burst overflow, DEPTH=4: 6 toggles on consecutive edges with `mem_gnt`=0 → first 4 queued, `overflow`=1; release grant → exactly 4 ack toggles in order (addresses checked), `busy` ends 0.
- Full plus simultaneous pop: FIFO full, DONE edge coincides with a new toggle → entry accepted, `overflow` stays 0, 5 acks total.
- `ds`=00 write: no `mem_req` is ever asserted; `port_ack` toggles 2 edges after the toggle.
- Reset mid-read: assert `reset_n`=0 during RWAIT → `mem_req`=0 immediately and all outputs at reset values; after release, a new toggle completes normally.
